stream_dup_map_n: RTL and testbench

Parametrised fan-out stage for compiled dataflow streams: each accepted input element is duplicated to `CHANNELS` output streams, and every copy is transformed by a per-channel map (add a channel constant). Each output has its own `DEPTH`-entry FIFO, so channels drain independently under separate backpressure. The block sits between a stream producer and several stream consumers in generated pipelines. It generalises the fixed two-way dup/map to N channels with buffering.

---
 rtl/stream_pkg.sv | 20 ++
 rtl/stream_fifo.sv | 64 ++++++
 rtl/stream_dup_map_n.sv | 69 ++++++
 tb/tb_stream_dup_map_n.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared stream types and helpers for the dup/map fan-out slice.
package stream_pkg;

  localparam int unsigned STREAM_WIDTH = 8;

  typedef logic signed [STREAM_WIDTH-1:0] stream_elem_t;

  // Map-op encoding; only ADD exists today, other codes are reserved.
  localparam logic [1:0] MAP_OP_ADD = 2'd0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Single-clock FIFO with valid/ready on both sides and a registered count.
// DEPTH must be a power of two; pointers wrap naturally, count separates full from empty.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        push_valid,
  output logic                        push_ready,
  input  logic [WIDTH-1:0]            push_data,
  output logic                        pop_valid,
  input  logic                        pop_ready,
  output logic [WIDTH-1:0]            pop_data,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    push_ready = (count_q < CW'(DEPTH));
    pop_valid  = (count_q != '0);
    do_push    = push_valid && push_ready;
    do_pop     = pop_valid && pop_ready;
    wr_ptr_d   = wr_ptr_q + AW'(do_push);
    rd_ptr_d   = rd_ptr_q + AW'(do_pop);
    count_d    = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; only pointers and count clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/stream_dup_map_n.sv
// Fan-out stage: each accepted element goes to every channel as sIn + k[c], one FIFO per channel.
// STREAM_DUP_MAP_SAT_EN selects signed saturating add; otherwise the add wraps.
module stream_dup_map_n
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic [WIDTH-1:0]                      sIn,
  input  logic                                  sIn_valid,
  output logic                                  sIn_ready,
  input  logic [CHANNELS*WIDTH-1:0]             k,
  output logic [CHANNELS*WIDTH-1:0]             sOut,
  output logic [CHANNELS-1:0]                   sOut_valid,
  input  logic [CHANNELS-1:0]                   sOut_ready,
  output logic [CHANNELS*clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [CHANNELS-1:0] ch_ready;
  logic                push;

  // All-or-nothing fan-out: accept only when every channel has room.
  assign sIn_ready = &ch_ready;
  assign push      = sIn_valid && sIn_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] mapped;

    assign addend = k[c*WIDTH +: WIDTH];

`ifdef STREAM_DUP_MAP_SAT_EN
    logic [WIDTH:0] sum;
    always_comb begin
      sum = {sIn[WIDTH-1], sIn} + {addend[WIDTH-1], addend};
      if (sum[WIDTH] != sum[WIDTH-1]) begin
        mapped = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        mapped = sum[WIDTH-1:0];
      end
    end
`else
    always_comb begin
      mapped = sIn + addend;
    end
`endif

    stream_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .nrst       (nrst),
      .push_valid (push),
      .push_ready (ch_ready[c]),
      .push_data  (mapped),
      .pop_valid  (sOut_valid[c]),
      .pop_ready  (sOut_ready[c]),
      .pop_data   (sOut[c*WIDTH +: WIDTH]),
      .count      (occupancy[c*CW +: CW])
    );
  end

endmodule

// File: tb/tb_stream_dup_map_n.sv
// Scoreboard bench: two instances (2ch/depth4 and 4ch/depth2) with per-channel expected queues.
module tb_stream_dup_map_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst;

  logic [7:0]  a_in;
  logic        a_in_valid, a_in_ready;
  logic [15:0] a_k, a_out;
  logic [1:0]  a_valid, a_rdy;
  logic [5:0]  a_occ;

  logic [7:0]  b_in;
  logic        b_in_valid, b_in_ready;
  logic [31:0] b_k, b_out;
  logic [3:0]  b_valid, b_rdy;
  logic [7:0]  b_occ;

  stream_dup_map_n #(.WIDTH(8), .CHANNELS(2), .DEPTH(4)) u_a (
    .clk(clk), .nrst(nrst), .sIn(a_in), .sIn_valid(a_in_valid), .sIn_ready(a_in_ready),
    .k(a_k), .sOut(a_out), .sOut_valid(a_valid), .sOut_ready(a_rdy), .occupancy(a_occ)
  );

  stream_dup_map_n #(.WIDTH(8), .CHANNELS(4), .DEPTH(2)) u_b (
    .clk(clk), .nrst(nrst), .sIn(b_in), .sIn_valid(b_in_valid), .sIn_ready(b_in_ready),
    .k(b_k), .sOut(b_out), .sOut_valid(b_valid), .sOut_ready(b_rdy), .occupancy(b_occ)
  );

  logic [7:0] qa [2][$];
  logic [7:0] qb [4][$];
  int n_cmp = 0;
  int n_bad = 0;
  int a_pushes;

`ifdef STREAM_DUP_MAP_SAT_EN
  localparam logic [7:0] EXP_POS_OVF = 8'h7F;
  localparam logic [7:0] EXP_NEG_OVF = 8'h80;
`else
  localparam logic [7:0] EXP_POS_OVF = 8'h82;
  localparam logic [7:0] EXP_NEG_OVF = 8'h7E;
`endif

  function automatic logic [7:0] map8(input logic [7:0] x, input logic [7:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
`ifdef STREAM_DUP_MAP_SAT_EN
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`endif
    return s[7:0];
  endfunction

  task automatic test_reset();
    nrst = 1'b1;
    #2 nrst = 1'b0;
    #1;
    n_cmp++;
    if (a_valid !== 2'b00 || a_occ !== 6'd0 || a_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_a: valid=%b occ=%h ready=%b want valid=00 occ=00 ready=1", a_valid, a_occ, a_in_ready);
    end
    n_cmp++;
    if (b_valid !== 4'b0000 || b_occ !== 8'd0 || b_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_b: valid=%b occ=%h ready=%b want valid=0000 occ=00 ready=1", b_valid, b_occ, b_in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_map_stream();
    int pushes = 0;
    a_k = {8'hFF, 8'h03};
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      a_in_valid = (cyc < 3);
      a_in = 8'(cyc);
      a_rdy = 2'b11;
      #1;
      n_cmp++;
      if (a_in_ready !== (qa[0].size() < 4 && qa[1].size() < 4)) begin
        n_bad++; $display("FAIL map_ready cyc%0d: got %b", cyc, a_in_ready);
      end
      for (int c = 0; c < 2; c++) begin
        n_cmp++;
        if (a_valid[c] !== (qa[c].size() != 0) || a_occ[c*3 +: 3] !== 3'(qa[c].size())) begin
          n_bad++;
          $display("FAIL map_valid_occ ch%0d cyc%0d: valid=%b occ=%0d want occ=%0d", c, cyc, a_valid[c], a_occ[c*3 +: 3], qa[c].size());
        end
        if (a_valid[c] && qa[c].size() != 0) begin
          n_cmp++;
          if (a_out[c*8 +: 8] !== qa[c][0]) begin
            n_bad++; $display("FAIL map_data ch%0d cyc%0d: got %h want %h", c, cyc, a_out[c*8 +: 8], qa[c][0]);
          end
          if (a_rdy[c]) void'(qa[c].pop_front());
        end
      end
      if (a_in_valid && a_in_ready) begin
        pushes++;
        for (int c = 0; c < 2; c++) qa[c].push_back(map8(a_in, a_k[c*8 +: 8]));
      end
    end
    n_cmp++;
    if (pushes != 3 || a_valid !== 2'b00) begin
      n_bad++; $display("FAIL map_drain: pushes=%0d valid=%b want 3 and 00", pushes, a_valid);
    end
  endtask

  task automatic test_backpressure();
    a_pushes = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      a_in_valid = (cyc < 12);
      a_in = 8'(8'd10 + 8'(a_pushes));
      a_rdy = (cyc == 8 || cyc >= 12) ? 2'b11 : 2'b01;
      #1;
      if (cyc == 8) begin
        n_cmp++;
        if (a_pushes != 4) begin
          n_bad++; $display("FAIL bp_fill_pushes: got %0d want 4", a_pushes);
        end
      end
      if (cyc == 12) begin
        n_cmp++;
        if (a_pushes != 5) begin
          n_bad++; $display("FAIL bp_one_pop_pushes: got %0d want 5", a_pushes);
        end
      end
      n_cmp++;
      if (a_in_ready !== (qa[0].size() < 4 && qa[1].size() < 4)) begin
        n_bad++; $display("FAIL bp_ready cyc%0d: got %b", cyc, a_in_ready);
      end
      for (int c = 0; c < 2; c++) begin
        n_cmp++;
        if (a_valid[c] !== (qa[c].size() != 0) || a_occ[c*3 +: 3] !== 3'(qa[c].size())) begin
          n_bad++;
          $display("FAIL bp_valid_occ ch%0d cyc%0d: valid=%b occ=%0d want occ=%0d", c, cyc, a_valid[c], a_occ[c*3 +: 3], qa[c].size());
        end
        if (a_valid[c] && qa[c].size() != 0) begin
          n_cmp++;
          if (a_out[c*8 +: 8] !== qa[c][0]) begin
            n_bad++; $display("FAIL bp_data ch%0d cyc%0d: got %h want %h", c, cyc, a_out[c*8 +: 8], qa[c][0]);
          end
          if (a_rdy[c]) void'(qa[c].pop_front());
        end
      end
      if (a_in_valid && a_in_ready) begin
        a_pushes++;
        for (int c = 0; c < 2; c++) qa[c].push_back(map8(a_in, a_k[c*8 +: 8]));
      end
    end
    n_cmp++;
    if (a_valid !== 2'b00 || qa[0].size() != 0 || qa[1].size() != 0) begin
      n_bad++; $display("FAIL bp_drain: valid=%b left=%0d/%0d want 00 0/0", a_valid, qa[0].size(), qa[1].size());
    end
  endtask

  task automatic test_saturation();
    a_k = {8'hF6, 8'h0A};
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      a_in_valid = (cyc < 2);
      a_in = (cyc == 0) ? 8'd120 : 8'h88;
      a_rdy = 2'b11;
      #1;
      if (cyc == 1) begin
        n_cmp++;
        if (a_valid[0] !== 1'b1 || a_out[7:0] !== EXP_POS_OVF) begin
          n_bad++; $display("FAIL sat_pos: got %h want %h", a_out[7:0], EXP_POS_OVF);
        end
      end
      if (cyc == 2) begin
        n_cmp++;
        if (a_valid[1] !== 1'b1 || a_out[15:8] !== EXP_NEG_OVF) begin
          n_bad++; $display("FAIL sat_neg: got %h want %h", a_out[15:8], EXP_NEG_OVF);
        end
      end
      for (int c = 0; c < 2; c++) begin
        n_cmp++;
        if (a_valid[c] !== (qa[c].size() != 0)) begin
          n_bad++; $display("FAIL sat_valid ch%0d cyc%0d: got %b", c, cyc, a_valid[c]);
        end
        if (a_valid[c] && qa[c].size() != 0) begin
          n_cmp++;
          if (a_out[c*8 +: 8] !== qa[c][0]) begin
            n_bad++; $display("FAIL sat_data ch%0d cyc%0d: got %h want %h", c, cyc, a_out[c*8 +: 8], qa[c][0]);
          end
          if (a_rdy[c]) void'(qa[c].pop_front());
        end
      end
      if (a_in_valid && a_in_ready) begin
        for (int c = 0; c < 2; c++) qa[c].push_back(map8(a_in, a_k[c*8 +: 8]));
      end
    end
  endtask

  task automatic test_reset_mid();
    a_k = {8'hFF, 8'h03};
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in = 8'(8'd50 + 8'(cyc));
      a_rdy = 2'b00;
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    n_cmp++;
    if (a_occ !== {3'd3, 3'd3} || a_valid !== 2'b11) begin
      n_bad++; $display("FAIL rstmid_before: occ=%h valid=%b want 1b and 11", a_occ, a_valid);
    end
    #2 nrst = 1'b0;
    #1;
    n_cmp++;
    if (a_valid !== 2'b00 || a_occ !== 6'd0 || a_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_async: valid=%b occ=%h ready=%b want 00 00 1", a_valid, a_occ, a_in_ready);
    end
    for (int c = 0; c < 2; c++) qa[c].delete();
    a_in_valid = 1'b1;
    a_in = 8'd99;
    a_rdy = 2'b11;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      a_in_valid = (cyc == 0);
      a_in = 8'd77;
      a_rdy = 2'b11;
      #1;
      for (int c = 0; c < 2; c++) begin
        n_cmp++;
        if (a_valid[c] !== (qa[c].size() != 0)) begin
          n_bad++; $display("FAIL rstmid_valid ch%0d cyc%0d: got %b", c, cyc, a_valid[c]);
        end
        if (a_valid[c] && qa[c].size() != 0) begin
          n_cmp++;
          if (a_out[c*8 +: 8] !== qa[c][0]) begin
            n_bad++; $display("FAIL rstmid_data ch%0d cyc%0d: got %h want %h", c, cyc, a_out[c*8 +: 8], qa[c][0]);
          end
          void'(qa[c].pop_front());
        end
      end
      if (a_in_valid && a_in_ready) begin
        for (int c = 0; c < 2; c++) qa[c].push_back(map8(a_in, a_k[c*8 +: 8]));
      end
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    int cyc = 0;
    bit done = 1'b0;
    b_k = {8'd100, 8'h80, 8'hF9, 8'd5};
    while (!done && cyc < 20000) begin
      @(negedge clk);
      b_in_valid = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      b_in = 8'($urandom);
      b_rdy = 4'($urandom);
      #1;
      n_cmp++;
      if (b_in_ready !== (qb[0].size() < 2 && qb[1].size() < 2 && qb[2].size() < 2 && qb[3].size() < 2)) begin
        n_bad++; $display("FAIL rand_ready cyc%0d: got %b", cyc, b_in_ready);
      end
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (b_valid[c] !== (qb[c].size() != 0) || b_occ[c*2 +: 2] !== 2'(qb[c].size())) begin
          n_bad++;
          $display("FAIL rand_valid_occ ch%0d cyc%0d: valid=%b occ=%0d want occ=%0d", c, cyc, b_valid[c], b_occ[c*2 +: 2], qb[c].size());
        end
        if (b_valid[c] && qb[c].size() != 0) begin
          n_cmp++;
          if (b_out[c*8 +: 8] !== qb[c][0]) begin
            n_bad++; $display("FAIL rand_data ch%0d cyc%0d: got %h want %h", c, cyc, b_out[c*8 +: 8], qb[c][0]);
          end
          if (b_rdy[c]) void'(qb[c].pop_front());
        end
      end
      if (b_in_valid && b_in_ready) begin
        pushed++;
        for (int c = 0; c < 4; c++) qb[c].push_back(map8(b_in, b_k[c*8 +: 8]));
      end
      cyc++;
      done = (pushed == 1000) && qb[0].size() == 0 && qb[1].size() == 0 &&
             qb[2].size() == 0 && qb[3].size() == 0;
    end
    n_cmp++;
    if (!done) begin
      n_bad++; $display("FAIL rand_timeout: pushed=%0d after %0d cycles want 1000 drained", pushed, cyc);
    end
  endtask

  initial begin
    nrst = 1'b1;
    a_in = '0; a_in_valid = 1'b0; a_k = '0; a_rdy = '0;
    b_in = '0; b_in_valid = 1'b0; b_k = '0; b_rdy = '0;
    test_reset();
    test_map_stream();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
